sha256_msg_padder: RTL and testbench

Front end of the SHA-256 datapath: accepts a message as a stream of 32-bit big-endian words and applies FIPS 180-4 padding (0x80 byte, zero fill, 64-bit bit-length). It writes each 512-bit block, one word per cycle, into the message scheduler's 16-word memory using the scheduler's load port (word, address, write enable). It then holds the block until the compression core acknowledges it.

---
 rtl/sha256_pkg.sv | 29 ++
 rtl/sha256_last_word_mask.sv | 25 ++
 rtl/sha256_msg_padder.sv | 189 ++++++++++++++++++
 tb/tb_sha256_msg_padder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 front-end definitions: padder state encoding, padding constants
// and the word-index helper used by the pad/length sequencer.
package sha256_pkg;

  typedef logic [2:0] pad_state_t;

  localparam pad_state_t ST_IDLE   = 3'd0;
  localparam pad_state_t ST_DATA   = 3'd1;
  localparam pad_state_t ST_PAD    = 3'd2;
  localparam pad_state_t ST_LEN_HI = 3'd3;
  localparam pad_state_t ST_LEN_LO = 3'd4;
  localparam pad_state_t ST_WAIT   = 3'd5;

  localparam logic [7:0] SHA256_PAD_BYTE        = 8'h80;
  localparam int         SHA256_WORDS_PER_BLOCK = 16;
  localparam logic [3:0] SHA256_LEN_HI_IDX      = 4'd14;
  localparam logic [3:0] SHA256_LEN_LO_IDX      = 4'd15;

  // State following a pad/zero word written at index idx.
  function automatic pad_state_t pad_next_state(input logic [3:0] idx);
    if (idx == SHA256_LEN_LO_IDX)
      return ST_WAIT;
    else if (idx == SHA256_LEN_HI_IDX - 4'd1)
      return ST_LEN_HI;
    else
      return ST_PAD;
  endfunction

endpackage

// File: rtl/sha256_last_word_mask.sv
// Final-transfer byte mask: keeps the first nbytes bytes, inserts 0x80, zero-fills.
// Exists only when SHA256_PADDER_BYTE_EN is defined.
`ifdef SHA256_PADDER_BYTE_EN
module sha256_last_word_mask
  import sha256_pkg::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  nbytes,
  output logic [31:0] word
);

  always_comb begin
    word = data;
    if (nbytes < 3'd4) begin
      for (int b = 0; b < 4; b++) begin
        if (3'(b) == nbytes)
          word[31-8*b -: 8] = SHA256_PAD_BYTE;
        else if (3'(b) > nbytes)
          word[31-8*b -: 8] = 8'h00;
      end
    end
  end

endmodule
`endif

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: streams words into the scheduler memory, appends 0x80,
// zero fill and bit length. Byte-granular final words need SHA256_PADDER_BYTE_EN.
//
// state  | meaning
// IDLE   | no message, length and word index cleared
// DATA   | accepting message words
// PAD    | writing the 0x80 word or zero words
// LEN_HI | writing word 14 = length[63:32]
// LEN_LO | writing word 15 = length[31:0]
// WAIT   | block complete, held until core_ack
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic [2:0]  in_nbytes,
  output logic [31:0] msg_word_out,
  output logic [3:0]  msg_word_addr,
  output logic        msg_write_en,
  output logic        block_start,
  output logic        block_valid,
  output logic        block_first,
  output logic        block_last,
  input  logic        core_ack,
  output logic        busy
);

  pad_state_t       state, state_n, pending, pending_n, cur_state;
  logic [3:0]       word_cnt, cnt_n, cur_cnt;
  logic [LEN_W-1:0] length, len_n;
  logic             first_flag, first_n, last_flag, last_n, pad80, pad80_n;
  logic             valid_n, we_n, start_n, accept;
  logic [31:0]      word_n, last_word;
  logic [3:0]       addr_n;
  logic [2:0]       eff_n;
  logic [63:0]      len64;

`ifdef SHA256_PADDER_BYTE_EN
  assign eff_n = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;

  sha256_last_word_mask u_mask (
    .data   (in_data),
    .nbytes (eff_n),
    .word   (last_word)
  );
`else
  assign eff_n     = (in_nbytes == 3'd0) ? 3'd0 : 3'd4;
  assign last_word = (eff_n == 3'd0) ? {SHA256_PAD_BYTE, 24'h0} : in_data;
`endif

  // A DATA block resumes on the ack edge itself so word 0 lands in the next cycle.
  assign in_ready = (state == ST_IDLE) || (state == ST_DATA) ||
                    ((state == ST_WAIT) && block_valid && core_ack && (pending == ST_DATA));
  assign accept      = in_valid && in_ready;
  assign busy        = (state != ST_IDLE);
  assign block_first = first_flag && block_valid;
  assign block_last  = last_flag && block_valid;

  always_comb begin
    len64 = '0;
    len64[LEN_W-1:0] = length;
  end

  always_comb begin
    state_n   = state;
    pending_n = pending;
    cnt_n     = word_cnt;
    len_n     = length;
    first_n   = first_flag;
    last_n    = last_flag;
    pad80_n   = pad80;
    valid_n   = block_valid;
    word_n    = msg_word_out;
    addr_n    = msg_word_addr;
    we_n      = 1'b0;
    start_n   = 1'b0;
    cur_state = state;
    cur_cnt   = word_cnt;

    if (state == ST_WAIT) begin
      if (!block_valid) begin
        valid_n = 1'b1;
      end else if (core_ack) begin
        valid_n = 1'b0;
        first_n = 1'b0;
        cnt_n   = 4'd0;
        cur_cnt = 4'd0;
        state_n = pending;
        if (pending == ST_IDLE) begin
          len_n  = '0;
          last_n = 1'b0;
        end else begin
          cur_state = pending;
        end
      end
    end

    case (cur_state)
      ST_IDLE, ST_DATA: begin
        if (accept) begin
          we_n    = 1'b1;
          addr_n  = cur_cnt;
          start_n = (cur_cnt == 4'd0);
          cnt_n   = cur_cnt + 4'd1;
          if (cur_state == ST_IDLE) first_n = 1'b1;
          if (!in_last) begin
            word_n  = in_data;
            len_n   = length + LEN_W'(32);
            state_n = (cur_cnt == 4'(SHA256_WORDS_PER_BLOCK - 1)) ? ST_WAIT : ST_DATA;
            pending_n = ST_DATA;
          end else begin
            word_n = last_word;
            len_n  = length + LEN_W'({eff_n, 3'b000});
            pending_n = ST_PAD;
            if (eff_n == 3'd4) begin
              pad80_n = 1'b1;
              state_n = (cur_cnt == SHA256_LEN_LO_IDX) ? ST_WAIT : ST_PAD;
            end else begin
              state_n = pad_next_state(cur_cnt);
            end
          end
        end
      end
      ST_PAD: begin
        we_n      = 1'b1;
        addr_n    = cur_cnt;
        start_n   = (cur_cnt == 4'd0);
        word_n    = pad80 ? {SHA256_PAD_BYTE, 24'h0} : 32'h0;
        pad80_n   = 1'b0;
        cnt_n     = cur_cnt + 4'd1;
        state_n   = pad_next_state(cur_cnt);
        pending_n = ST_PAD;
      end
      ST_LEN_HI: begin
        we_n    = 1'b1;
        addr_n  = SHA256_LEN_HI_IDX;
        word_n  = len64[63:32];
        cnt_n   = SHA256_LEN_LO_IDX;
        state_n = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        we_n      = 1'b1;
        addr_n    = SHA256_LEN_LO_IDX;
        word_n    = len64[31:0];
        state_n   = ST_WAIT;
        pending_n = ST_IDLE;
        last_n    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      pending       <= ST_IDLE;
      word_cnt      <= 4'd0;
      length        <= '0;
      first_flag    <= 1'b0;
      last_flag     <= 1'b0;
      pad80         <= 1'b0;
      block_valid   <= 1'b0;
      msg_word_out  <= 32'h0;
      msg_word_addr <= 4'd0;
      msg_write_en  <= 1'b0;
      block_start   <= 1'b0;
    end else begin
      state         <= state_n;
      pending       <= pending_n;
      word_cnt      <= cnt_n;
      length        <= len_n;
      first_flag    <= first_n;
      last_flag     <= last_n;
      pad80         <= pad80_n;
      block_valid   <= valid_n;
      msg_word_out  <= word_n;
      msg_word_addr <= addr_n;
      msg_write_en  <= we_n;
      block_start   <= start_n;
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder; expectations follow SHA256_PADDER_BYTE_EN
// when the bench is built with it.
module tb_sha256_msg_padder;

  logic        clk = 1'b0;
  logic        reset_n, in_valid, in_ready, in_last;
  logic [31:0] in_data, msg_word_out;
  logic [2:0]  in_nbytes;
  logic [3:0]  msg_word_addr;
  logic        msg_write_en, block_start, block_valid, block_first, block_last;
  logic        core_ack, busy;

  int total = 0;
  int bad   = 0;
  logic [31:0] mem   [16];
  logic [31:0] exp_w [16];

  always #5 clk = ~clk;

  sha256_msg_padder #(.LEN_W(64)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_last       (in_last),
    .in_nbytes     (in_nbytes),
    .msg_word_out  (msg_word_out),
    .msg_word_addr (msg_word_addr),
    .msg_write_en  (msg_write_en),
    .block_start   (block_start),
    .block_valid   (block_valid),
    .block_first   (block_first),
    .block_last    (block_last),
    .core_ack      (core_ack),
    .busy          (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Advance to the next falling edge and capture any scheduler write.
  task automatic step();
    @(negedge clk);
    if (msg_write_en === 1'b1) mem[msg_word_addr] = msg_word_out;
  endtask

  task automatic clr_mem();
    for (int i = 0; i < 16; i++) begin
      mem[i]   = 32'hDEADBEEF;
      exp_w[i] = 32'h0;
    end
  endtask

  task automatic send(input logic [31:0] d, input logic l, input logic [2:0] n);
    bit ok = 1'b0;
    in_valid  = 1'b1;
    in_data   = d;
    in_last   = l;
    in_nbytes = n;
    for (int t = 0; t < 200 && !ok; t++) begin
      ok = in_ready;
      step();
    end
    chk("send_accept", 64'(ok), 64'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_blk(input string tag, input logic first, input logic last);
    for (int t = 0; t < 300; t++) begin
      if (block_valid === 1'b1) break;
      step();
    end
    chk({tag, "_valid"}, 64'(block_valid), 64'd1);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s_w%0d", tag, i), 64'(mem[i]), 64'(exp_w[i]));
    chk({tag, "_first"}, 64'(block_first), 64'(first));
    chk({tag, "_last"}, 64'(block_last), 64'(last));
  endtask

  task automatic ack();
    clr_mem();
    core_ack = 1'b1;
    step();
    core_ack = 1'b0;
    chk("ack_valid_drop", 64'(block_valid), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_we"}, 64'(msg_write_en), 64'd0);
    chk({tag, "_word"}, 64'(msg_word_out), 64'd0);
    chk({tag, "_addr"}, 64'(msg_word_addr), 64'd0);
    chk({tag, "_start"}, 64'(block_start), 64'd0);
    chk({tag, "_valid"}, 64'(block_valid), 64'd0);
    chk({tag, "_first"}, 64'(block_first), 64'd0);
    chk({tag, "_last"}, 64'(block_last), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic run_abc(input string tag);
    clr_mem();
    send(32'h61626300, 1'b1, 3'd3);
`ifdef SHA256_PADDER_BYTE_EN
    exp_w[0]  = 32'h61626380;
    exp_w[15] = 32'h00000018;
`else
    exp_w[0]  = 32'h61626300;
    exp_w[1]  = 32'h80000000;
    exp_w[15] = 32'h00000020;
`endif
    wait_blk(tag, 1'b1, 1'b1);
    ack();
    chk({tag, "_busy_end"}, 64'(busy), 64'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    in_last   = 1'b0;
    in_nbytes = 3'd0;
    core_ack  = 1'b0;
    clr_mem();
    step();
    step();
    check_reset_outputs("por");
    reset_n = 1'b1;
    step();

    run_abc("abc");

    clr_mem();
    send(32'hFFFFFFFF, 1'b1, 3'd0);
    exp_w[0] = 32'h80000000;
    wait_blk("empty", 1'b1, 1'b1);
    ack();

    // 14 words: 0x80 lands at 14, length spills into a second block.
    clr_mem();
    for (int i = 0; i < 14; i++) send(32'h20000000 + i, (i == 13), 3'd4);
    for (int i = 0; i < 14; i++) exp_w[i] = 32'h20000000 + i;
    exp_w[14] = 32'h80000000;
    wait_blk("w14_b1", 1'b1, 1'b0);
    ack();
    exp_w[15] = 32'h000001C0;
    wait_blk("w14_b2", 1'b0, 1'b1);
    ack();

    clr_mem();
    for (int i = 0; i < 16; i++) send(32'h30000000 + i, (i == 15), 3'd4);
    for (int i = 0; i < 16; i++) exp_w[i] = 32'h30000000 + i;
    wait_blk("w16_b1", 1'b1, 1'b0);
    ack();
    exp_w[0]  = 32'h80000000;
    exp_w[15] = 32'h00000200;
    wait_blk("w16_b2", 1'b0, 1'b1);
    ack();

    // Backpressure: next word held at the input while the block waits for ack.
    clr_mem();
    for (int i = 0; i < 16; i++) send(32'h40000000 + i, 1'b0, 3'd0);
    for (int i = 0; i < 16; i++) exp_w[i] = 32'h40000000 + i;
    wait_blk("bp_b1", 1'b1, 1'b0);
    in_valid  = 1'b1;
    in_data   = 32'hA1B2C3D4;
    in_last   = 1'b1;
    in_nbytes = 3'd2;
    for (int t = 0; t < 10; t++) begin
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_we", 64'(msg_write_en), 64'd0);
      chk("bp_valid", 64'(block_valid), 64'd1);
      step();
    end
    clr_mem();
    core_ack = 1'b1;
    step();
    core_ack = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("bp_w0_we", 64'(msg_write_en), 64'd1);
    chk("bp_w0_addr", 64'(msg_word_addr), 64'd0);
    chk("bp_w0_start", 64'(block_start), 64'd1);
    chk("bp_valid_drop", 64'(block_valid), 64'd0);
`ifdef SHA256_PADDER_BYTE_EN
    exp_w[0]  = 32'hA1B28000;
    exp_w[15] = 32'h00000210;
`else
    exp_w[0]  = 32'hA1B2C3D4;
    exp_w[1]  = 32'h80000000;
    exp_w[15] = 32'h00000220;
`endif
    chk("bp_w0_word", 64'(msg_word_out), 64'(exp_w[0]));
    wait_blk("bp_b2", 1'b0, 1'b1);
    ack();

    // Asynchronous reset while word 7 is being presented.
    clr_mem();
    for (int i = 0; i < 7; i++) send(32'h50000000 + i, 1'b0, 3'd0);
    in_valid = 1'b1;
    in_data  = 32'h50000007;
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst");
    in_valid = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    run_abc("abc_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
